// File: rtl/fifo_word_reader.sv
// Drains an 8-bit byte FIFO (registered flags, one-cycle read latency) and packs bytes into
// WORD_BYTES-wide words for a valid/ready sink. Define FIFO_WORD_READER_FLUSH_EN for partial-word flush.
module fifo_word_reader #(
    parameter int WORD_BYTES   = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        out_read_ctrl,
    input  logic [7:0]                  in_read_data,
    input  logic                        in_is_empty,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*WORD_BYTES-1:0]     out_data,
    output logic [$clog2(WORD_BYTES):0] out_bytes,
    output logic                        out_flushed
);
    localparam int               CNT_W = $clog2(WORD_BYTES) + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    if (WORD_BYTES < 2 || FLUSH_CYCLES < 1) begin : g_param_check
        $error("fifo_word_reader: needs WORD_BYTES >= 2 and FLUSH_CYCLES >= 1");
    end

    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cap_pending;
    logic             flush_fire;
    logic             pop_ok;

    assign cnt_next = byte_cnt + ONE;

    // Pops are never back-to-back, so the FIFO's registered empty flag is always current
    // when the decision is made; cap_pending reserves a lane for the byte still in flight.
    assign pop_ok = !in_is_empty && !out_read_ctrl && !out_valid && !flush_fire
                  && ((byte_cnt + CNT_W'(cap_pending)) < FULL);

`ifdef FIFO_WORD_READER_FLUSH_EN
    localparam int                IDLE_W   = $clog2(FLUSH_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_CYCLES);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_tick;

    assign idle_tick  = (byte_cnt != '0) && (byte_cnt < FULL) && !out_valid && in_is_empty
                      && !out_read_ctrl && !cap_pending;
    assign flush_fire = !out_valid && (byte_cnt != '0) && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (rst || flush_fire || cap_pending || out_read_ctrl || !in_is_empty) begin
            idle_cnt <= '0;
        end else if (idle_tick && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign flush_fire = 1'b0;
`endif

    // Sink handshake: a word transfers in any cycle with out_valid & out_ready; while out_valid
    // is high and out_ready low, out_data/out_bytes/out_flushed hold. out_ready is ignored when
    // out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_read_ctrl <= 1'b0;
            cap_pending   <= 1'b0;
            byte_cnt      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_bytes     <= '0;
            out_flushed   <= 1'b0;
        end else begin
            out_read_ctrl <= pop_ok;
            cap_pending   <= out_read_ctrl;
            if (out_valid) begin
                if (out_ready) begin
                    out_valid   <= 1'b0;
                    byte_cnt    <= '0;
                    out_data    <= '0;
                    out_bytes   <= '0;
                    out_flushed <= 1'b0;
                end
            end else if (cap_pending) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (byte_cnt == CNT_W'(i)) begin
                        out_data[8*i +: 8] <= in_read_data;
                    end
                end
                byte_cnt <= cnt_next;
                if (cnt_next == FULL) begin
                    out_valid   <= 1'b1;
                    out_bytes   <= FULL;
                    out_flushed <= 1'b0;
                end
            end else if (flush_fire) begin
                // Unfilled lanes are already zero: lanes are cleared on every handshake.
                out_valid   <= 1'b1;
                out_bytes   <= byte_cnt;
                out_flushed <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_word_reader.md
# fifo_word_reader

Read-side engine that drains the 8-bit byte FIFO and packs bytes into WORD_BYTES-wide words for a downstream valid/ready consumer. It drives the FIFO's read control from its empty flag and never pops an empty FIFO. It accounts for the FIFO's one-cycle registered read latency and registered flags. It sits between the byte FIFO's read port and a word-wide sink such as a bus writer or DMA.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per output word (≥2).
- FLUSH_CYCLES, 16, consecutive idle cycles before a partial word is flushed (≥1; used only with flush compiled in).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- out_read_ctrl  output  1  FIFO pop; registered.
- in_read_data  input  8  FIFO read data, valid in the cycle after out_read_ctrl.
- in_is_empty  input  1  FIFO empty flag (registered in FIFO).
- out_valid  output  1  word available.
- out_ready  input  1  sink accepts word.
- out_data  output  8*WORD_BYTES  packed word; first-popped byte in bits [7:0].
- out_bytes  output  $clog2(WORD_BYTES)+1  count of valid bytes in out_data.
- out_flushed  output  1  word is a timeout-flushed partial word.

## Operation
- Internal state:
  - byte_cnt: 0..WORD_BYTES.
  - cap_pending: a pop was issued last cycle.
  - idle_cnt: flush timer.
- Pop rule: out_read_ctrl is set for the next cycle when all of the following hold in the current cycle:
  - in_is_empty=0
  - out_read_ctrl=0 (no back-to-back pops, so the registered empty flag is always current)
  - out_valid=0
  - byte_cnt + cap_pending < WORD_BYTES
- Capture: in the cycle after a pop, in_read_data is written to lane byte_cnt (bits [8*byte_cnt+7 : 8*byte_cnt]), and byte_cnt increments.
- Word complete: when a capture makes byte_cnt=WORD_BYTES, the next cycle shows out_valid=1, out_bytes=WORD_BYTES and out_flushed=0.
- Handshake:
  - out_data, out_bytes and out_flushed are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: next cycle out_valid=0, byte_cnt=0, and all lanes are cleared to 0.
- No pop is issued while out_valid=1.
- out_ready while out_valid=0 is ignored.

## Timing
- Reset values: out_read_ctrl=0, out_valid=0, out_data=0, out_bytes=0, out_flushed=0, byte_cnt=0, idle_cnt=0.
- Pop cadence: at most one pop every 2 cycles, so sustained throughput is 1 byte per 2 cycles.
- Latency, pop to capture: pop in cycle t, data captured at the end of cycle t+1.
- Latency, last byte to word: last pop in cycle t gives out_valid=1 in cycle t+2.
- Full word from a non-empty FIFO (WORD_BYTES=4):
  - pops in cycles t, t+2, t+4, t+6
  - out_valid in cycle t+8
- After a handshake in cycle h, the earliest next pop is cycle h+2 (decided in h+1).
- Empty boundary:
  - If in_is_empty=1, no pop is issued; byte_cnt holds.
  - A pop already issued still completes its capture.
- Reset mid-operation:
  - Partial word discarded; any in-flight capture dropped.
  - All outputs at reset values in the cycle after rst is sampled high.
  - rst overrides out_ready.

## Configuration
- Macro: FIFO_WORD_READER_FLUSH_EN.
- Defined:
  - idle_cnt increments each cycle in which all hold: 0<byte_cnt<WORD_BYTES, out_valid=0, in_is_empty=1, out_read_ctrl=0, and no capture.
  - idle_cnt clears on any capture, any pop, or any cycle in which in_is_empty=0.
  - When idle_cnt reaches FLUSH_CYCLES, the next cycle shows out_valid=1, out_bytes=byte_cnt and out_flushed=1; unused lanes are 0; idle_cnt clears.
  - The handshake is identical to a full word.
- Undefined:
  - No timer; partial words wait indefinitely for more bytes.
  - out_flushed is tied 0; out_bytes is always WORD_BYTES when valid; FLUSH_CYCLES is unused.

## Test plan
- Full word, no backpressure:
  - Stimulus: FIFO holds 0x11,0x22,0x33,0x44; out_ready=1.
  - Response: pops exactly 2 cycles apart; out_data=0x44332211, out_bytes=4, out_flushed=0; out_valid high for exactly 1 cycle, at pop1+8.
- Backpressure:
  - Stimulus: same word with out_ready=0 for 5 cycles.
  - Response: out_valid and out_data=0x44332211 held stable; no pops during the stall; next pop 2 cycles after the handshake.
- Empty protection:
  - Stimulus: FIFO holds 1 byte, then goes empty for 40 cycles (flush undefined).
  - Response: exactly 1 pop; out_read_ctrl never high while in_is_empty=1; out_valid stays 0.
- Timeout flush (FIFO_WORD_READER_FLUSH_EN defined):
  - Stimulus: 0xAA then 0xBB, then the FIFO stays empty.
  - Response: 16 idle cycles after the last capture, out_data=0x0000BBAA, out_bytes=2, out_flushed=1.
- Flush timer restart:
  - Stimulus: a byte arrives at idle_cnt=10.
  - Response: idle_cnt clears; no flush; byte_cnt increments.
- Reset mid-word:
  - Stimulus: rst for 1 cycle after 3 captures (0x01,0x02,0x03), then 0x04..0x07 written to the FIFO.
  - Response: outputs return to 0; the next word is 0x07060504, not a mix with 0x01..0x03.
